// File: rtl/mcu_pkg.sv
// Shared types and default widths for the register-file multiply unit.
package mcu_pkg;

    localparam int DEF_ADDR_SIZE = 5;
    localparam int DEF_DATA_SIZE = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MUL   = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4
    } mul_state_t;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add datapath: one partial product per step.
// The multiplicand is kept pre-shifted in a double-width register, so each
// step only needs an add and two shifts instead of a variable shifter.
module shift_add_mul
    import mcu_pkg::*;
#(
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   load,
    input  logic                   step,
    input  logic [DATA_SIZE-1:0]   mcand,
    input  logic [DATA_SIZE-1:0]   mplier,
    output logic                   last,
    output logic [2*DATA_SIZE-1:0] product
);

    localparam int CW = $clog2(DATA_SIZE) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);

    logic [2*DATA_SIZE-1:0] acc_reg;
    logic [2*DATA_SIZE-1:0] mcand_reg;
    logic [DATA_SIZE-1:0]   mplier_reg;
    logic [CW-1:0]          cnt_reg;
    logic [2*DATA_SIZE-1:0] addend;

    // Partial product: the shifted multiplicand gated by the current multiplier LSB.
    for (genvar gi = 0; gi < 2*DATA_SIZE; gi++) begin : g_addend
        assign addend[gi] = mcand_reg[gi] & mplier_reg[0];
    end

    // The step in progress is the final one when the counter reaches DATA_SIZE-1.
    assign last    = (cnt_reg == LAST_CNT);
    assign product = acc_reg;

    // Load operands and clear state, or accumulate one bit of the product per step.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc_reg    <= '0;
            mcand_reg  <= '0;
            mplier_reg <= '0;
            cnt_reg    <= '0;
        end else if (load) begin
            acc_reg    <= '0;
            mcand_reg  <= {{DATA_SIZE{1'b0}}, mcand};
            mplier_reg <= mplier;
            cnt_reg    <= '0;
        end else if (step) begin
            acc_reg    <= acc_reg + addend;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_reg >> 1;
            cnt_reg    <= cnt_reg + CW'(1);
        end
    end

endmodule

// File: rtl/rf_mul_unit.sv
// Multiplier that borrows the register file ports: reads RD and RS, multiplies
// them over DATA_SIZE cycles, then writes the low half to RD and the high half
// to RD+1 (wrapping at the top of the register file).
module rf_mul_unit
    import mcu_pkg::*;
#(
    parameter int ADDR_SIZE = DEF_ADDR_SIZE,
    parameter int DATA_SIZE = DEF_DATA_SIZE
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic [ADDR_SIZE-1:0] RD,
    input  logic [ADDR_SIZE-1:0] RS,
    input  logic [DATA_SIZE-1:0] RF_DX,
    input  logic [DATA_SIZE-1:0] RF_DY,
    output logic [ADDR_SIZE-1:0] RF_ADRX,
    output logic [ADDR_SIZE-1:0] RF_ADRY,
    output logic [DATA_SIZE-1:0] RF_DIN,
    output logic                 RF_WE,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 C,
    output logic                 Z
);

    mul_state_t             state_reg;
    logic [ADDR_SIZE-1:0]   rd_q_reg;
    logic [ADDR_SIZE-1:0]   rs_q_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   c_reg;
    logic                   z_reg;
    logic                   mul_last;
    logic [2*DATA_SIZE-1:0] mul_product;

    shift_add_mul #(
        .DATA_SIZE (DATA_SIZE)
    ) u_mul (
        .CLK     (CLK),
        .RST     (RST),
        .load    (state_reg == LOAD),
        .step    (state_reg == MUL),
        .mcand   (RF_DX),
        .mplier  (RF_DY),
        .last    (mul_last),
        .product (mul_product)
    );

    // Control FSM with registered BUSY/DONE and result flags.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= IDLE;
            rd_q_reg  <= '0;
            rs_q_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            c_reg     <= 1'b0;
            z_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (START) begin
                        rd_q_reg  <= RD;
                        rs_q_reg  <= RS;
                        busy_reg  <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: state_reg <= MUL;
                MUL: begin
                    if (mul_last) begin
                        state_reg <= WR_LO;
                    end
                end
                WR_LO: begin
                    done_reg  <= 1'b1;
                    state_reg <= WR_HI;
                end
                WR_HI: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    c_reg     <= |mul_product[2*DATA_SIZE-1:DATA_SIZE];
                    z_reg     <= (mul_product == '0);
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // Register file port decode from the registered state. The write enable is
    // also masked by RST so that a reset landing on a write cycle blocks that
    // write instead of letting it commit on the same edge.
    always_comb begin
        RF_ADRX = '0;
        RF_ADRY = '0;
        RF_DIN  = '0;
        RF_WE   = 1'b0;
        case (state_reg)
            LOAD: begin
                RF_ADRX = rd_q_reg;
                RF_ADRY = rs_q_reg;
            end
            WR_LO: begin
                RF_ADRX = rd_q_reg;
                RF_DIN  = mul_product[DATA_SIZE-1:0];
                RF_WE   = ~RST;
            end
            WR_HI: begin
                RF_ADRX = rd_q_reg + ADDR_SIZE'(1);
                RF_DIN  = mul_product[2*DATA_SIZE-1:DATA_SIZE];
                RF_WE   = ~RST;
            end
            default: begin
                RF_ADRX = '0;
            end
        endcase
    end

    assign BUSY = busy_reg;
    assign DONE = done_reg;
    assign C    = c_reg;
    assign Z    = z_reg;

endmodule

// File: tb/tb_rf_mul_unit.sv
// Directed bench for rf_mul_unit with a behavioural register file and a
// scoreboard of expected products.
module tb_rf_mul_unit;

    localparam int AS = 5;
    localparam int DS = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic [AS-1:0] RD = '0;
    logic [AS-1:0] RS = '0;
    logic [DS-1:0] rf_dx, rf_dy, rf_din;
    logic [AS-1:0] rf_adrx, rf_adry;
    logic          rf_we, busy, done, c_flag, z_flag;

    // bench-side write port used to preload registers while the unit is idle
    logic          tb_we = 1'b0;
    logic [AS-1:0] tb_adr = '0;
    logic [DS-1:0] tb_din = '0;

    logic [DS-1:0] rf [32];
    int            we_total = 0;
    int            checks = 0;
    int            failures = 0;

    typedef struct {
        logic [AS-1:0] rd;
        logic [DS-1:0] lo;
        logic [DS-1:0] hi;
        logic          c;
        logic          z;
    } exp_t;
    exp_t exp_q[$];

    always #5 CLK = ~CLK;

    rf_mul_unit #(.ADDR_SIZE(AS), .DATA_SIZE(DS)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .RD      (RD),
        .RS      (RS),
        .RF_DX   (rf_dx),
        .RF_DY   (rf_dy),
        .RF_ADRX (rf_adrx),
        .RF_ADRY (rf_adry),
        .RF_DIN  (rf_din),
        .RF_WE   (rf_we),
        .BUSY    (busy),
        .DONE    (done),
        .C       (c_flag),
        .Z       (z_flag)
    );

    assign rf_dx = rf[rf_adrx];
    assign rf_dy = rf[rf_adry];

    always @(posedge CLK) begin
        if (tb_we) rf[tb_adr] <= tb_din;
        else if (rf_we) rf[rf_adrx] <= rf_din;
    end

    always @(posedge CLK) begin
        if (rf_we) we_total <= we_total + 1;
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    task automatic rf_wr(input logic [AS-1:0] a, input logic [DS-1:0] d);
        tb_we = 1'b1; tb_adr = a; tb_din = d;
        @(posedge CLK); #1;
        tb_we = 1'b0;
    endtask

    task automatic push_exp(input logic [AS-1:0] rd, input logic [DS-1:0] a, input logic [DS-1:0] b);
        exp_t e;
        logic [2*DS-1:0] p;
        p = {{DS{1'b0}}, a} * {{DS{1'b0}}, b};
        e.rd = rd;
        e.lo = p[DS-1:0];
        e.hi = p[2*DS-1:DS];
        e.c  = (p[2*DS-1:DS] != '0);
        e.z  = (p == '0);
        exp_q.push_back(e);
    endtask

    // Issue one operation; optionally re-pulse START (with different indices)
    // or raise RST so that it is sampled at the given edge number.
    task automatic do_op(input logic [AS-1:0] rd, input logic [AS-1:0] rs,
                         input int restart_at, input int rst_at,
                         output int done_edge, output int idle_edge, output int writes);
        int we0;
        we0 = we_total;
        START = 1'b1; RD = rd; RS = rs;
        @(posedge CLK); #1;
        START = 1'b0;
        check("busy_at_edge0", 32'(busy), 32'd1);
        done_edge = -1;
        idle_edge = -1;
        for (int k = 1; k <= 20; k++) begin
            START = (k == restart_at);
            if (k == restart_at) begin
                RD = rd + AS'(5);
                RS = rs + AS'(3);
            end
            RST = (k == rst_at);
            @(posedge CLK); #1;
            if (done && done_edge < 0) done_edge = k;
            if (!busy) begin
                idle_edge = k;
                break;
            end
        end
        START = 1'b0;
        RST = 1'b0;
        writes = we_total - we0;
    endtask

    task automatic score(input string tag, input int done_edge, input int idle_edge, input int writes);
        exp_t e;
        logic [AS-1:0] hi_idx;
        e = exp_q.pop_front();
        hi_idx = e.rd + AS'(1);
        check({tag, "_done_edge"}, 32'(done_edge), 32'(DS + 2));
        check({tag, "_idle_edge"}, 32'(idle_edge), 32'(DS + 3));
        check({tag, "_we_cycles"}, 32'(writes), 32'd2);
        check({tag, "_lo"}, 32'(rf[e.rd]), 32'(e.lo));
        check({tag, "_hi"}, 32'(rf[hi_idx]), 32'(e.hi));
        check({tag, "_c"}, 32'(c_flag), 32'(e.c));
        check({tag, "_z"}, 32'(z_flag), 32'(e.z));
        $display("op %s rd=%0d lo=0x%02h hi=0x%02h c=%0d z=%0d done_edge=%0d writes=%0d",
                 tag, e.rd, rf[e.rd], rf[hi_idx], c_flag, z_flag, done_edge, writes);
    endtask

    initial begin
        int de, ie, wr;

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_adrx", 32'(rf_adrx), 32'd0);
        check("rst_adry", 32'(rf_adry), 32'd0);
        check("rst_din", 32'(rf_din), 32'd0);
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_c", 32'(c_flag), 32'd0);
        check("rst_z", 32'(z_flag), 32'd0);

        // 13 * 11 = 0x008F
        rf_wr(5'd3, 8'd13); rf_wr(5'd4, 8'd11);
        push_exp(5'd3, 8'd13, 8'd11);
        do_op(5'd3, 5'd4, 0, 0, de, ie, wr);
        score("basic", de, ie, wr);

        // 0xFF * 0xFF = 0xFE01
        rf_wr(5'd5, 8'hFF); rf_wr(5'd6, 8'hFF);
        push_exp(5'd5, 8'hFF, 8'hFF);
        do_op(5'd5, 5'd6, 0, 0, de, ie, wr);
        score("max", de, ie, wr);

        // 0x5A * 0 = 0
        rf_wr(5'd7, 8'h5A); rf_wr(5'd2, 8'h00); rf_wr(5'd8, 8'hC3);
        push_exp(5'd7, 8'h5A, 8'h00);
        do_op(5'd7, 5'd2, 0, 0, de, ie, wr);
        score("zero", de, ie, wr);

        // START re-pulsed at edge 4 must be ignored
        rf_wr(5'd9, 8'd3); rf_wr(5'd10, 8'd7);
        push_exp(5'd9, 8'd3, 8'd7);
        do_op(5'd9, 5'd10, 4, 0, de, ie, wr);
        score("restart", de, ie, wr);

        // RD=RS=31: high half wraps to register 0
        rf_wr(5'd31, 8'h10); rf_wr(5'd0, 8'hAA);
        push_exp(5'd31, 8'h10, 8'h10);
        do_op(5'd31, 5'd31, 0, 0, de, ie, wr);
        score("wrap", de, ie, wr);

        // reset during MUL: nothing written, flags cleared
        rf_wr(5'd12, 8'h33); rf_wr(5'd13, 8'h44); rf_wr(5'd14, 8'h55);
        do_op(5'd12, 5'd14, 0, 5, de, ie, wr);
        check("rstmul_idle_edge", 32'(ie), 32'd5);
        check("rstmul_we_cycles", 32'(wr), 32'd0);
        check("rstmul_no_done", 32'(de), 32'hFFFF_FFFF);
        check("rstmul_r12", 32'(rf[12]), 32'h33);
        check("rstmul_r13", 32'(rf[13]), 32'h44);
        check("rstmul_c", 32'(c_flag), 32'd0);
        $display("op rstmul idle_edge=%0d writes=%0d r12=0x%02h r13=0x%02h", ie, wr, rf[12], rf[13]);

        // reset during WR_HI: low half (0x20*0x77=0x0EE0 -> 0xE0) kept, high half blocked
        rf_wr(5'd15, 8'h20); rf_wr(5'd16, 8'h77);
        do_op(5'd15, 5'd16, 0, DS + 3, de, ie, wr);
        check("rsthi_idle_edge", 32'(ie), 32'(DS + 3));
        check("rsthi_we_cycles", 32'(wr), 32'd1);
        check("rsthi_r15", 32'(rf[15]), 32'hE0);
        check("rsthi_r16", 32'(rf[16]), 32'h77);
        check("rsthi_c", 32'(c_flag), 32'd0);
        check("rsthi_we_after", 32'(rf_we), 32'd0);
        $display("op rsthi idle_edge=%0d writes=%0d r15=0x%02h r16=0x%02h", ie, wr, rf[15], rf[16]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rf_mul_unit.md
# rf_mul_unit

Iterative unsigned multiplier attached directly to the dual-port register file. On a start request it reads two operands through the register file's asynchronous read ports and runs a DATA_SIZE-cycle shift-add multiply. It then writes the 2×DATA_SIZE product back through the file's synchronous write port: low half to RD, high half to RD+1. While BUSY is high the control unit routes the register file's ADRX/ADRY/DIN/WE from this block; otherwise the block's address/write outputs are don't-care except RF_WE, which is 0.

## Interface
- ADDR_SIZE, 5, register file address width
- DATA_SIZE, 8, register/operand width; product is 2×DATA_SIZE
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- START  in  1  request; sampled only in IDLE
- RD  in  ADDR_SIZE  destination / first-operand register index
- RS  in  ADDR_SIZE  second-operand register index
- RF_DX  in  DATA_SIZE  register file DX_OUT (async read of RF_ADRX)
- RF_DY  in  DATA_SIZE  register file DY_OUT (async read of RF_ADRY)
- RF_ADRX  out  ADDR_SIZE  register file ADRX
- RF_ADRY  out  ADDR_SIZE  register file ADRY
- RF_DIN  out  DATA_SIZE  register file DIN
- RF_WE  out  1  register file WE
- BUSY  out  1  unit owns register file ports
- DONE  out  1  one-cycle pulse, final write in progress
- C  out  1  high half of last product nonzero
- Z  out  1  last full product is zero

## Operation
- States: IDLE, LOAD, MUL, WR_LO, WR_HI.
- IDLE: START=1 captures RD, RS into registers; go to LOAD. START=0: stay.
- LOAD: RF_ADRX=RD_q, RF_ADRY=RS_q; register RF_DX as multiplicand and RF_DY as multiplier; clear accumulator and iteration counter; go to MUL.
- MUL: one iteration per cycle. If multiplier LSB=1, add multiplicand (zero-extended to 2×DATA_SIZE, shifted by iteration) to accumulator. Shift multiplier right. After exactly DATA_SIZE iterations, go to WR_LO.
- Arithmetic: unsigned, accumulator 2×DATA_SIZE bits, no overflow possible.
- WR_LO: RF_WE=1, RF_ADRX=RD_q, RF_DIN=product[DATA_SIZE-1:0]; go to WR_HI.
- WR_HI: RF_WE=1, RF_ADRX=RD_q+1 mod 2^ADDR_SIZE (RD=31 writes high half to register 0), RF_DIN=product high half, DONE=1; go to IDLE and update C, Z.
- RD=RS is legal: operands are latched in LOAD before any write.
- START while not IDLE: ignored, no queuing.
- RST (any state): next state IDLE. No further writes occur. A low half already committed in WR_LO stays in the register file.
- Reset values: RF_ADRX=0, RF_ADRY=0, RF_DIN=0, RF_WE=0, BUSY=0, DONE=0, C=0, Z=0.
- RF_WE is 1 only in WR_LO and WR_HI.

## Timing
- Edge 0: START=1 sampled in IDLE; BUSY=1 from edge 0.
- Cycle after edge 0: LOAD. Operands registered at edge 1.
- Edges 1..DATA_SIZE: MUL cycles, DATA_SIZE of them.
- Edge DATA_SIZE+1: enter WR_LO.
- Edge DATA_SIZE+2: low half committed; enter WR_HI; DONE=1.
- Edge DATA_SIZE+3: high half committed; IDLE; BUSY=0, DONE=0; C/Z valid.
- Total occupancy: DATA_SIZE+3 cycles (11 at default). A new START may be sampled at edge DATA_SIZE+3.
- BUSY and DONE are registered, state-decoded outputs. RF_* outputs are decoded from registered state only.

## Structure
- Shared package mcu_pkg holds:
  - mul_state_t enum (IDLE, LOAD, MUL, WR_LO, WR_HI)
  - default width constants
- Sub-module shift_add_mul: accumulator, multiplier shift register, iteration counter. Interface: load, step, last, product.
- rf_mul_unit keeps the FSM, index registers, register file port decode, and C/Z flags.

## Test plan
- R3=13, R4=11; START, RD=3, RS=4: R3=0x8F, R4=0x00. C=0, Z=0. DONE pulses at edge 10. BUSY low at edge 11.
- R5=0xFF, R6=0xFF; RD=5, RS=6: R5=0x01, R6=0xFE. C=1, Z=0.
- R7=0x5A, R2=0x00; RD=7, RS=2: R7=0x00, R8=0x00. C=0, Z=1.
- RD=31, RS=31, R31=0x10: R31=0x00, R0=0x01. C=1. Wrap verified.
- START pulsed again at edge 4 of an operation: ignored. Exactly two RF_WE cycles occur; result unchanged.
- RST asserted during MUL (edge 5): IDLE next edge, BUSY=0, RF_WE never asserted, all registers unchanged. RST during WR_HI: low half written, high half not written.
